dht_sensor_controller: RTL
==========================

// Module: dht_sensor_controller
// PURPOSE
//  Parametrised single-wire DHT11/DHT22 humidity/temperature controller, successor to the 8-bit DHT11 controller.
//  Issues start pulses periodically or on demand, decodes the 40-bit frame and validates the checksum.
//  Reports scaled x10 readings plus error status.
//  Sits between the board dht_data pad and the home-appliance control/display logic.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency; all timings derived from it via a 1 us tick
//  SENSOR_TYPE   0            0 = DHT11 (integral/decimal bytes), 1 = DHT22 (16-bit, sign-magnitude temp)
//  POLL_MS       3000         auto-poll period in ms; 0 disables auto-poll (trigger only)
//  START_LOW_US  18000        host start-low duration (DHT22 uses >=1000)
//  TIMEOUT_US    200          max duration of any single sensor phase before timeout_err
//  BIT_THRESH_US 40           data-high duration >= threshold decodes as 1, else 0
// PORTS
//  clk            in     1   system clock
//  reset          in     1   asynchronous, active-low reset
//  trigger        in     1   1-cycle request to start a read; ignored while busy
//  dht_data       inout  1   sensor line; driven only as 0 or Z, never 1 (external pull-up)
//  humidity_x10   out    16  relative humidity in 0.1 %RH units, unsigned
//  temp_x10       out    16  temperature in 0.1 degC units, two's complement
//  data_valid     out    1   1-cycle pulse when a frame passes checksum and outputs update
//  checksum_err   out    1   1-cycle pulse on checksum mismatch
//  timeout_err    out    1   1-cycle pulse on phase timeout
//  busy           out    1   high from leaving IDLE until return to IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; dht_data released (Z); FSM in IDLE; poll counter cleared.
//  dht_data input passes through a 2-FF synchroniser. All edge detection uses the synchronised copy.
//  FSM:
//   IDLE: leave on trigger or poll expiry, whichever comes first; both at once count as one read.
//         Poll counter restarts on every read start.
//   START_LOW: drive 0 for START_LOW_US.
//   START_REL: release the line. Wait for a falling edge, timeout after TIMEOUT_US.
//   RESP_LOW -> RESP_HIGH: sensor 80 us low, then 80 us high. Each waits for the opposite edge or times out.
//   BIT_LOW -> BIT_HIGH: measure the high width in us. Shift in MSB first. Repeat for 40 bits.
//   CHECK: one cycle, then IDLE.
//  Any phase exceeding TIMEOUT_US -> ERR: pulse timeout_err, release line, return to IDLE. Outputs are held.
//  Checksum rule: B4 == (B0+B1+B2+B3) mod 256.
//   Match: update outputs, pulse data_valid, both in the same cycle.
//   Mismatch: pulse checksum_err, outputs are held.
//  Scaling:
//   DHT11: humidity_x10 = B0*10 + B1; temp_x10 = B2*10 + B3.
//   DHT22: humidity_x10 = {B0,B1}; temp_x10 = B2[7] ? -{B2[6:0],B3} : {B2[6:0],B3}.
//  Latency: outputs update 1 cycle after the last bit's falling edge is observed; trigger to busy is 1 cycle.
//  Reset mid-frame: immediate release of the line, IDLE, outputs return to 0. No pulse is emitted.
//  Bit counter wraps are not allowed; exactly 40 bits, and extra edges after CHECK are ignored.
// CONFIGURATION
//  DHT_ERR_CNT_EN defined:
//   adds outputs crc_err_cnt[7:0] and timeout_cnt[7:0], saturating at 255, cleared only by reset.
//  Not defined: ports absent, no counters synthesised; all other behaviour identical.
// STRUCTURE
//  Package dht_pkg holds:
//   FSM state typedef, SENSOR_DHT11/SENSOR_DHT22 constants,
//   NUM_BITS=40, function us_to_cycles(CLK_HZ).
//  Sub-module dht_us_tick: free-running 1 us strobe generator from CLK_HZ, shared by all timers.
// TESTING
//  DHT11, trigger, frame 3C_00_1C_00_58 (80/80 us response, 50 us low, 28/70 us high)
//   -> humidity_x10=600, temp_x10=280, one data_valid pulse, busy low afterwards.
//  DHT11, frame 3C_00_1C_00_59 -> checksum_err pulse; outputs keep 600/280 from the prior read; no data_valid.
//  No sensor response after start release
//   -> timeout_err ~200 us after release; line Z; FSM IDLE; outputs unchanged.
//  SENSOR_TYPE=1, frames 02_8C_01_5F_EE then 02_8C_80_65_73
//   -> 652/351, then 652/-101 (temp_x10=16'hFF9B).
//  Assert reset (low) in the middle of bit 20 -> line Z within one cycle, all outputs 0.
//   Then a fresh trigger decodes correctly.
//  POLL_MS scaled small, trigger coinciding with poll expiry
//   -> exactly one start pulse; with DHT_ERR_CNT_EN, counters increment and saturate at 255.

Source files
------------

// File: rtl/dht_pkg.sv
// dht_pkg - shared definitions for the DHT11/DHT22 controller.
//   dht_state_t    : controller FSM states
//   SENSOR_DHT11/22: SENSOR_TYPE encodings
//   NUM_BITS       : bits per sensor frame
//   us_to_cycles   : clock cycles per microsecond for a given clock rate
//   frame_crc_ok   : checksum test on a full 40-bit frame
package dht_pkg;

  localparam int unsigned SENSOR_DHT11 = 0;
  localparam int unsigned SENSOR_DHT22 = 1;
  localparam int unsigned NUM_BITS     = 40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_START_REL,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_ERR
  } dht_state_t;

  // Clocks below 1 MHz still get a tick every cycle rather than never.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz);
    int unsigned c;
    c = clk_hz / 1_000_000;
    return (c == 0) ? 1 : c;
  endfunction

  // Frame layout is B0..B4 from MSB to LSB; B4 is the mod-256 sum of B0..B3.
  function automatic logic frame_crc_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/dht_sensor_controller_us_tick.sv
// dht_us_tick - free-running 1 us strobe shared by every timer in the controller.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   tick  : one-cycle pulse every microsecond (every cycle when CLK_HZ <= 1 MHz)
module dht_us_tick
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = us_to_cycles(CLK_HZ);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_sensor_controller.sv
// dht_sensor_controller - single-wire DHT11/DHT22 humidity/temperature reader.
// Starts a read on trigger or auto-poll expiry, decodes the 40-bit frame,
// validates the checksum and presents x10-scaled readings.
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   trigger      : one-cycle read request, ignored while busy
//   dht_data     : sensor line, driven 0 or released (external pull-up)
//   humidity_x10 : relative humidity, 0.1 %RH, unsigned
//   temp_x10     : temperature, 0.1 degC, two's complement
//   data_valid   : pulse when a good frame updates the outputs
//   checksum_err : pulse on checksum mismatch
//   timeout_err  : pulse when a sensor phase exceeds TIMEOUT_US
//   busy         : high while a read is in progress
// Optional build macro DHT_ERR_CNT_EN adds saturating crc_err_cnt / timeout_cnt.
module dht_sensor_controller
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned SENSOR_TYPE   = SENSOR_DHT11,
  parameter int unsigned POLL_MS       = 3000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  inout  wire         dht_data,
  output logic [15:0] humidity_x10,
  output logic [15:0] temp_x10,
  output logic        data_valid,
  output logic        checksum_err,
  output logic        timeout_err,
  output logic        busy
`ifdef DHT_ERR_CNT_EN
  ,
  output logic [7:0]  crc_err_cnt,
  output logic [7:0]  timeout_cnt
`endif
);

  localparam int unsigned POLL_US = POLL_MS * 1000;

  dht_state_t  state, state_next;
  logic        tick;
  logic [2:0]  sync_q;
  logic        rise, fall;
  logic [31:0] us_cnt, poll_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shift_q, frame_next;
  logic        bit_val, last_bit, timed_out, poll_due, read_start, drive_low;
  logic [15:0] hum_dec, temp_dec, temp_mag;

  dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign dht_data = drive_low ? 1'b0 : 1'bz;

  // sync_q[1:0] is the 2-FF synchroniser, sync_q[2] the previous synchronised sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[1:0], dht_data};
  end

  assign rise       = sync_q[1] & ~sync_q[2];
  assign fall       = ~sync_q[1] & sync_q[2];
  assign timed_out  = (us_cnt >= 32'(TIMEOUT_US));
  assign bit_val    = (us_cnt >= 32'(BIT_THRESH_US));
  assign last_bit   = (bit_cnt == 6'(NUM_BITS - 1));
  assign frame_next = {shift_q[38:0], bit_val};
  assign poll_due   = (POLL_US != 0) && (poll_cnt == 32'(POLL_US));
  assign read_start = (state == ST_IDLE) && (trigger || poll_due);

  always_comb begin
    temp_mag = {1'b0, frame_next[22:8]};
    if (SENSOR_TYPE == SENSOR_DHT22) begin
      hum_dec  = frame_next[39:24];
      temp_dec = frame_next[23] ? (~temp_mag + 16'd1) : temp_mag;
    end else begin
      hum_dec  = 16'(frame_next[39:32]) * 16'd10 + 16'(frame_next[31:24]);
      temp_dec = 16'(frame_next[23:16]) * 16'd10 + 16'(frame_next[15:8]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (read_start) state_next = ST_START_LOW;
      ST_START_LOW: if (us_cnt >= 32'(START_LOW_US)) state_next = ST_START_REL;
      ST_START_REL: if (fall) state_next = ST_RESP_LOW;
                    else if (timed_out) state_next = ST_ERR;
      ST_RESP_LOW:  if (rise) state_next = ST_RESP_HIGH;
                    else if (timed_out) state_next = ST_ERR;
      ST_RESP_HIGH: if (fall) state_next = ST_BIT_LOW;
                    else if (timed_out) state_next = ST_ERR;
      ST_BIT_LOW:   if (rise) state_next = ST_BIT_HIGH;
                    else if (timed_out) state_next = ST_ERR;
      ST_BIT_HIGH:  if (fall) state_next = last_bit ? ST_CHECK : ST_BIT_LOW;
                    else if (timed_out) state_next = ST_ERR;
      ST_CHECK:     state_next = ST_IDLE;
      ST_ERR:       state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    drive_low    = (state == ST_START_LOW);
    busy         = (state != ST_IDLE);
    data_valid   = (state == ST_CHECK) &&  frame_crc_ok(shift_q);
    checksum_err = (state == ST_CHECK) && !frame_crc_ok(shift_q);
    timeout_err  = (state == ST_ERR);
  end

  // Phase timer: restarts on every state change, so it measures both phase
  // duration (timeouts) and the data-high width in BIT_HIGH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        us_cnt <= '0;
    else if (state_next != state || state == ST_IDLE) us_cnt <= '0;
    else if (tick && us_cnt != '1)                     us_cnt <= us_cnt + 32'd1;
  end

  // Saturates at the poll period so an expiry seen while busy starts a read on return to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  poll_cnt <= '0;
    else if (read_start)                         poll_cnt <= '0;
    else if (tick && poll_cnt != 32'(POLL_US))   poll_cnt <= poll_cnt + 32'd1;
  end

  // Outputs load on entry to CHECK from the completed frame so they change
  // in the same cycle data_valid is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      humidity_x10 <= '0;
      temp_x10     <= '0;
    end else begin
      if (read_start) bit_cnt <= '0;
      if (state == ST_BIT_HIGH && fall) begin
        shift_q <= frame_next;
        bit_cnt <= bit_cnt + 6'd1;
        if (last_bit && frame_crc_ok(frame_next)) begin
          humidity_x10 <= hum_dec;
          temp_x10     <= temp_dec;
        end
      end
    end
  end

`ifdef DHT_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (checksum_err && crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 8'd1;
      if (timeout_err  && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule
